// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: learns each round's sequence from the LEDs and replays it as timed button presses.
// Define JOGADOR_ERRO_EN to corrupt play ERR_JOGADA of round ERR_RODADA (rotated left by one bit) for negative testing.
module jogador_automatico #(
  parameter int HOLD       = 10,
  parameter int GAP        = 10,
  parameter int QUIET      = 20,
  parameter int START_LEN  = 5,
  parameter int DEPTH      = 16,
  parameter int ERR_RODADA = 3,
  parameter int ERR_JOGADA = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       comecar,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       iniciar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic [3:0] rodada,
  output logic       estouro,
  output logic [2:0] db_estado
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (((HOLD > GAP) ? HOLD : GAP) > START_LEN) ? ((HOLD > GAP) ? HOLD : GAP) : START_LEN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int QW   = $clog2(QUIET + 1);

  localparam logic [TW-1:0] HOLD_M1  = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_M1   = TW'(GAP - 1);
  localparam logic [TW-1:0] START_M1 = TW'(START_LEN - 1);
  localparam logic [QW-1:0] QUIET_C  = QW'(QUIET);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  if (HOLD < 1 || GAP < 1 || QUIET < 1 || START_LEN < 1 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || ERR_RODADA < 1 || ERR_JOGADA < 1) begin : g_bad_params
    $error("jogador_automatico: invalid parameter set");
  end

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    INICIA    = 3'd1,
    ESCUTA    = 3'd2,
    PRESSIONA = 3'd3,
    SOLTA     = 3'd4,
    FIM       = 3'd5
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    leds_q, leds_prev_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rodada_q, rodada_d;
  logic          estouro_q, estouro_d;
  logic          iniciar_q, iniciar_d;
  logic          ocupado_q, ocupado_d;
  logic [3:0]    botoes_q, botoes_d;
  logic [3:0]    press_val;
  logic          wr_en;
  logic          game_end;
  logic [3:0]    mem [DEPTH];

  assign game_end = pronto | ganhou | perdeu;

  // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    quiet_d   = quiet_q;
    timer_d   = timer_q;
    rodada_d  = rodada_q;
    estouro_d = estouro_q;
    wr_en     = 1'b0;

    unique case (state_q)
      OCIOSO: begin
        if (comecar) begin
          state_d   = INICIA;
          rodada_d  = '0;
          estouro_d = 1'b0;
          count_d   = '0;
          quiet_d   = '0;
          timer_d   = '0;
        end
      end
      INICIA: begin
        if (timer_q == START_M1) begin
          state_d = ESCUTA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ESCUTA: begin
        // A capture is the registered display going from dark to lit.
        if (leds_q != '0 && leds_prev_q == '0) begin
          if (count_q == DEPTH_C) begin
            estouro_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        if (leds_q != '0) begin
          quiet_d = '0;
        end else if (count_q != '0 && quiet_q != QUIET_C) begin
          quiet_d = quiet_q + QW'(1);
        end
        if (quiet_q == QUIET_C) begin
          state_d = PRESSIONA;
          idx_d   = '0;
          timer_d = '0;
          if (rodada_q != 4'hF) rodada_d = rodada_q + 4'd1;
        end
      end
      PRESSIONA: begin
        if (timer_q == HOLD_M1) begin
          state_d = SOLTA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SOLTA: begin
        if (timer_q == GAP_M1) begin
          timer_d = '0;
          idx_d   = idx_q + CW'(1);
          if (idx_q + CW'(1) == count_q) begin
            state_d = ESCUTA;
            count_d = '0;
            quiet_d = '0;
          end else begin
            state_d = PRESSIONA;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FIM: begin
        if (!comecar) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase

    if (game_end && (state_q == ESCUTA || state_q == PRESSIONA || state_q == SOLTA)) begin
      state_d = FIM;
    end
  end

  // Outputs are the decoded next state, registered; memory and round are stable for a whole press.
  always_comb begin
    press_val = mem[idx_d[AW-1:0]];
`ifdef JOGADOR_ERRO_EN
    if (rodada_d == 4'(ERR_RODADA) && idx_d == CW'(ERR_JOGADA - 1)) begin
      press_val = {press_val[2:0], press_val[3]};
    end
`endif
    botoes_d  = (state_d == PRESSIONA) ? press_val : 4'b0000;
    iniciar_d = (state_d == INICIA);
    ocupado_d = (state_d != OCIOSO);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      leds_q      <= '0;
      leds_prev_q <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      quiet_q     <= '0;
      timer_q     <= '0;
      rodada_q    <= '0;
      estouro_q   <= 1'b0;
      iniciar_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      botoes_q    <= '0;
    end else begin
      state_q     <= state_d;
      leds_q      <= leds;
      leds_prev_q <= leds_q;
      count_q     <= count_d;
      idx_q       <= idx_d;
      quiet_q     <= quiet_d;
      timer_q     <= timer_d;
      rodada_q    <= rodada_d;
      estouro_q   <= estouro_d;
      iniciar_q   <= iniciar_d;
      ocupado_q   <= ocupado_d;
      botoes_q    <= botoes_d;
    end
  end

  // NOTE: the sequence memory is not reset; each entry is written before it is replayed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[count_q[AW-1:0]] <= leds_q;
  end

  assign iniciar   = iniciar_q;
  assign botoes    = botoes_q;
  assign ocupado   = ocupado_q;
  assign rodada    = rodada_q;
  assign estouro   = estouro_q;
  assign db_estado = state_q;

endmodule
